// File: rtl/id_ex_operand_stage_if.sv
// Bus between decode, the ID/EX operand stage and the ALU: upstream beat,
// forwarding sources, flush and the registered ALU-side outputs.
interface id_ex_operand_stage_if #(
  parameter int DATA_W     = 32,
  parameter int OP_W       = 4,
  parameter int REG_ADDR_W = 5
);
  logic                  in_valid;
  logic                  in_ready;
  logic [OP_W-1:0]       in_alu_op;
  logic [REG_ADDR_W-1:0] in_rs1_addr;
  logic [REG_ADDR_W-1:0] in_rs2_addr;
  logic [DATA_W-1:0]     in_rs1_data;
  logic [DATA_W-1:0]     in_rs2_data;
  logic [DATA_W-1:0]     in_imm;
  logic                  in_use_imm;
  logic [REG_ADDR_W-1:0] in_rd_addr;
  logic                  in_reg_write;
  logic                  flush;
  logic                  fwd_exmem_valid;
  logic [REG_ADDR_W-1:0] fwd_exmem_rd;
  logic [DATA_W-1:0]     fwd_exmem_data;
  logic                  fwd_memwb_valid;
  logic [REG_ADDR_W-1:0] fwd_memwb_rd;
  logic [DATA_W-1:0]     fwd_memwb_data;
  logic                  out_valid;
  logic                  out_ready;
  logic [OP_W-1:0]       ALU_Operation;
  logic [DATA_W-1:0]     rd1;
  logic [DATA_W-1:0]     rd2;
  logic [REG_ADDR_W-1:0] out_rd_addr;
  logic                  out_reg_write;

  // The stage itself is the slave; decode/hazard/ALU side is the master.
  modport slave (
    input  in_valid, in_alu_op, in_rs1_addr, in_rs2_addr, in_rs1_data,
           in_rs2_data, in_imm, in_use_imm, in_rd_addr, in_reg_write, flush,
           fwd_exmem_valid, fwd_exmem_rd, fwd_exmem_data,
           fwd_memwb_valid, fwd_memwb_rd, fwd_memwb_data, out_ready,
    output in_ready, out_valid, ALU_Operation, rd1, rd2, out_rd_addr,
           out_reg_write
  );

  modport master (
    output in_valid, in_alu_op, in_rs1_addr, in_rs2_addr, in_rs1_data,
           in_rs2_data, in_imm, in_use_imm, in_rd_addr, in_reg_write, flush,
           fwd_exmem_valid, fwd_exmem_rd, fwd_exmem_data,
           fwd_memwb_valid, fwd_memwb_rd, fwd_memwb_data, out_ready,
    input  in_ready, out_valid, ALU_Operation, rd1, rd2, out_rd_addr,
           out_reg_write
  );
endinterface

// File: rtl/id_ex_operand_stage.sv
// ID/EX pipeline register feeding the ALU, with EX/MEM and MEM/WB operand
// forwarding at capture and MEM/WB snooping while the entry is stalled.
module id_ex_operand_stage #(
  parameter int DATA_W     = 32,
  parameter int OP_W       = 4,
  parameter int REG_ADDR_W = 5
) (
  input logic                   clk,
  input logic                   n_rst,
  id_ex_operand_stage_if.slave  bus
);

  logic                  valid_q;
  logic [OP_W-1:0]       op_q;
  logic [DATA_W-1:0]     rd1_q;
  logic [DATA_W-1:0]     rd2_q;
  logic [REG_ADDR_W-1:0] rd_addr_q;
  logic [REG_ADDR_W-1:0] rs1_q;
  logic [REG_ADDR_W-1:0] rs2_q;
  logic                  use_imm_q;
  logic                  reg_write_q;

  logic                  capture;
  logic                  hold;
  logic                  snoop1;
  logic                  snoop2;
  logic [DATA_W-1:0]     cap_rd1;
  logic [DATA_W-1:0]     cap_rd2;

  // Register index 0 is hardwired and must never pick up a forwarded value.
  function automatic logic [DATA_W-1:0] fwd_sel(
    input logic [REG_ADDR_W-1:0] rs,
    input logic [DATA_W-1:0]     rf_data,
    input logic                  ex_v,
    input logic [REG_ADDR_W-1:0] ex_rd,
    input logic [DATA_W-1:0]     ex_d,
    input logic                  wb_v,
    input logic [REG_ADDR_W-1:0] wb_rd,
    input logic [DATA_W-1:0]     wb_d
  );
    logic [DATA_W-1:0] sel;
    sel = rf_data;
    if (rs != '0) begin
      if (ex_v && ex_rd == rs)      sel = ex_d;
      else if (wb_v && wb_rd == rs) sel = wb_d;
    end
    return sel;
  endfunction

  assign bus.in_ready = !valid_q || bus.out_ready || bus.flush;
  assign capture      = bus.in_valid && bus.in_ready && !bus.flush;
  assign hold         = valid_q && !bus.out_ready && !bus.flush;

  assign snoop1 = hold && bus.fwd_memwb_valid && bus.fwd_memwb_rd != '0 &&
                  bus.fwd_memwb_rd == rs1_q;
  assign snoop2 = hold && bus.fwd_memwb_valid && bus.fwd_memwb_rd != '0 &&
                  bus.fwd_memwb_rd == rs2_q && !use_imm_q;

  always_comb begin
    cap_rd1 = fwd_sel(bus.in_rs1_addr, bus.in_rs1_data,
                      bus.fwd_exmem_valid, bus.fwd_exmem_rd, bus.fwd_exmem_data,
                      bus.fwd_memwb_valid, bus.fwd_memwb_rd, bus.fwd_memwb_data);
    cap_rd2 = bus.in_imm;
    if (!bus.in_use_imm)
      cap_rd2 = fwd_sel(bus.in_rs2_addr, bus.in_rs2_data,
                        bus.fwd_exmem_valid, bus.fwd_exmem_rd, bus.fwd_exmem_data,
                        bus.fwd_memwb_valid, bus.fwd_memwb_rd, bus.fwd_memwb_data);
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst)            valid_q <= 1'b0;
    else if (bus.flush)    valid_q <= 1'b0;
    else if (capture)      valid_q <= 1'b1;
    else if (bus.out_ready) valid_q <= 1'b0;
  end

  // A new capture wins over the hold snoop; a drained entry keeps its payload.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      op_q        <= '0;
      rd1_q       <= '0;
      rd2_q       <= '0;
      rd_addr_q   <= '0;
      rs1_q       <= '0;
      rs2_q       <= '0;
      use_imm_q   <= 1'b0;
      reg_write_q <= 1'b0;
    end else if (bus.flush) begin
      op_q        <= '0;
      rd1_q       <= '0;
      rd2_q       <= '0;
      rd_addr_q   <= '0;
      rs1_q       <= '0;
      rs2_q       <= '0;
      use_imm_q   <= 1'b0;
      reg_write_q <= 1'b0;
    end else if (capture) begin
      op_q        <= bus.in_alu_op;
      rd1_q       <= cap_rd1;
      rd2_q       <= cap_rd2;
      rd_addr_q   <= bus.in_rd_addr;
      rs1_q       <= bus.in_rs1_addr;
      rs2_q       <= bus.in_rs2_addr;
      use_imm_q   <= bus.in_use_imm;
      reg_write_q <= bus.in_reg_write;
    end else begin
      if (snoop1) rd1_q <= bus.fwd_memwb_data;
      if (snoop2) rd2_q <= bus.fwd_memwb_data;
    end
  end

  assign bus.out_valid     = valid_q;
  assign bus.ALU_Operation = op_q;
  assign bus.rd1           = rd1_q;
  assign bus.rd2           = rd2_q;
  assign bus.out_rd_addr   = rd_addr_q;
  assign bus.out_reg_write = reg_write_q && valid_q;

endmodule
